// File: rtl/nearest_centroid.sv
// Nearest-centroid search: scans K stored centroids one per cycle and reports the index and
// Manhattan distance of the closest one. Optional per-centroid sums: NEAREST_CENTROID_ACCUM_EN.
module nearest_centroid #(
  parameter int X_WIDTH       = 9,
  parameter int Y_WIDTH       = 8,
  parameter int NUM_CENTROIDS = 4,
`ifdef NEAREST_CENTROID_ACCUM_EN
  parameter int SUM_WIDTH     = 24,
`endif
  localparam int IDX_WIDTH    = $clog2(NUM_CENTROIDS),
  localparam int DIST_WIDTH   = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  centroid_we_in,
  input  logic [IDX_WIDTH-1:0]  centroid_idx_in,
  input  logic [X_WIDTH-1:0]    centroid_x_in,
  input  logic [Y_WIDTH-1:0]    centroid_y_in,
  input  logic                  point_valid_in,
  output logic                  point_ready_out,
  input  logic [X_WIDTH-1:0]    point_x_in,
  input  logic [Y_WIDTH-1:0]    point_y_in,
  output logic                  result_valid_out,
  input  logic                  result_ready_in,
  output logic [IDX_WIDTH-1:0]  best_idx_out,
  output logic [DIST_WIDTH-1:0] best_dist_out
`ifdef NEAREST_CENTROID_ACCUM_EN
  ,
  input  logic                  accum_clear_in,
  input  logic [IDX_WIDTH-1:0]  accum_rd_idx_in,
  output logic [SUM_WIDTH-1:0]  accum_sum_x_out,
  output logic [SUM_WIDTH-1:0]  accum_sum_y_out,
  output logic [SUM_WIDTH-1:0]  accum_count_out
`endif
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                state_q, state_d;
  logic [X_WIDTH-1:0]    px_q, px_d;
  logic [Y_WIDTH-1:0]    py_q, py_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [DIST_WIDTH-1:0] best_dist_q, best_dist_d;
  logic [X_WIDTH-1:0]    cx_q [NUM_CENTROIDS];
  logic [X_WIDTH-1:0]    cx_d [NUM_CENTROIDS];
  logic [Y_WIDTH-1:0]    cy_q [NUM_CENTROIDS];
  logic [Y_WIDTH-1:0]    cy_d [NUM_CENTROIDS];

  logic                  accept;
  logic                  scan_last;
  logic                  idx_ok;
  logic [X_WIDTH-1:0]    cur_cx, dx;
  logic [Y_WIDTH-1:0]    cur_cy, dy;
  logic [DIST_WIDTH-1:0] cur_dist;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StScan;
      StScan:  if (scan_last) state_d = StDone;
      StDone:  if (result_ready_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is gated by reset so nothing is offered a handshake while reset is held.
  always_comb begin
    point_ready_out  = (state_q == StIdle) && !rst_in;
    result_valid_out = (state_q == StDone);
    best_idx_out     = best_idx_q;
    best_dist_out    = best_dist_q;
  end

  assign accept    = point_valid_in && point_ready_out;
  assign scan_last = (cnt_q == IDX_WIDTH'(NUM_CENTROIDS - 1));
  assign idx_ok    = (32'(centroid_idx_in) < 32'(NUM_CENTROIDS));

  // Manhattan distance; each term fits its own width, so the sum needs one extra bit.
  always_comb begin
    cur_cx   = cx_q[cnt_q];
    cur_cy   = cy_q[cnt_q];
    dx       = (px_q >= cur_cx) ? (px_q - cur_cx) : (cur_cx - px_q);
    dy       = (py_q >= cur_cy) ? (py_q - cur_cy) : (cur_cy - py_q);
    cur_dist = DIST_WIDTH'(dx) + DIST_WIDTH'(dy);
  end

  always_comb begin
    px_d        = px_q;
    py_d        = py_q;
    cnt_d       = cnt_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    if (state_q == StIdle) begin
      if (centroid_we_in && idx_ok) begin
        cx_d[centroid_idx_in] = centroid_x_in;
        cy_d[centroid_idx_in] = centroid_y_in;
      end
      if (accept) begin
        px_d  = point_x_in;
        py_d  = point_y_in;
        cnt_d = '0;
      end
    end
    if (state_q == StScan) begin
      cnt_d = cnt_q + IDX_WIDTH'(1);
      // Strict less-than keeps the lowest index on ties.
      if ((cnt_q == '0) || (cur_dist < best_dist_q)) begin
        best_idx_d  = cnt_q;
        best_dist_d = cur_dist;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      px_q        <= '0;
      py_q        <= '0;
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      cx_q        <= '{default: '0};
      cy_q        <= '{default: '0};
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      cnt_q       <= cnt_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
    end
  end

`ifdef NEAREST_CENTROID_ACCUM_EN
  logic [SUM_WIDTH-1:0] acc_x_q [NUM_CENTROIDS];
  logic [SUM_WIDTH-1:0] acc_x_d [NUM_CENTROIDS];
  logic [SUM_WIDTH-1:0] acc_y_q [NUM_CENTROIDS];
  logic [SUM_WIDTH-1:0] acc_y_d [NUM_CENTROIDS];
  logic [SUM_WIDTH-1:0] acc_n_q [NUM_CENTROIDS];
  logic [SUM_WIDTH-1:0] acc_n_d [NUM_CENTROIDS];

  // best_idx_d on the last scan cycle is the final winner.
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    acc_n_d = acc_n_q;
    if (accum_clear_in) begin
      acc_x_d = '{default: '0};
      acc_y_d = '{default: '0};
      acc_n_d = '{default: '0};
    end else if ((state_q == StScan) && scan_last) begin
      acc_x_d[best_idx_d] = acc_x_q[best_idx_d] + SUM_WIDTH'(px_q);
      acc_y_d[best_idx_d] = acc_y_q[best_idx_d] + SUM_WIDTH'(py_q);
      acc_n_d[best_idx_d] = acc_n_q[best_idx_d] + SUM_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_x_q <= '{default: '0};
      acc_y_q <= '{default: '0};
      acc_n_q <= '{default: '0};
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      acc_n_q <= acc_n_d;
    end
  end

  always_comb begin
    accum_sum_x_out = acc_x_q[accum_rd_idx_in];
    accum_sum_y_out = acc_y_q[accum_rd_idx_in];
    accum_count_out = acc_n_q[accum_rd_idx_in];
  end
`endif

endmodule

// File: tb/tb_nearest_centroid.sv
// Directed bench for nearest_centroid (K=4, 9-bit x, 8-bit y); accumulator checks only when
// NEAREST_CENTROID_ACCUM_EN is defined.
module tb_nearest_centroid;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       centroid_we_in;
  logic [1:0] centroid_idx_in;
  logic [8:0] centroid_x_in;
  logic [7:0] centroid_y_in;
  logic       point_valid_in;
  logic       point_ready_out;
  logic [8:0] point_x_in;
  logic [7:0] point_y_in;
  logic       result_valid_out;
  logic       result_ready_in;
  logic [1:0] best_idx_out;
  logic [9:0] best_dist_out;
`ifdef NEAREST_CENTROID_ACCUM_EN
  logic        accum_clear_in;
  logic [1:0]  accum_rd_idx_in;
  logic [23:0] accum_sum_x_out;
  logic [23:0] accum_sum_y_out;
  logic [23:0] accum_count_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  nearest_centroid dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .centroid_we_in   (centroid_we_in),
    .centroid_idx_in  (centroid_idx_in),
    .centroid_x_in    (centroid_x_in),
    .centroid_y_in    (centroid_y_in),
    .point_valid_in   (point_valid_in),
    .point_ready_out  (point_ready_out),
    .point_x_in       (point_x_in),
    .point_y_in       (point_y_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .best_idx_out     (best_idx_out),
    .best_dist_out    (best_dist_out)
`ifdef NEAREST_CENTROID_ACCUM_EN
    ,
    .accum_clear_in   (accum_clear_in),
    .accum_rd_idx_in  (accum_rd_idx_in),
    .accum_sum_x_out  (accum_sum_x_out),
    .accum_sum_y_out  (accum_sum_y_out),
    .accum_count_out  (accum_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [8:0] x, input logic [7:0] y);
    centroid_we_in  = 1'b1;
    centroid_idx_in = idx;
    centroid_x_in   = x;
    centroid_y_in   = y;
    tick();
    centroid_we_in  = 1'b0;
  endtask

  // Presents a point for one cycle; the accepting edge is the tick inside.
  task automatic start(input logic [8:0] x, input logic [7:0] y);
    point_valid_in = 1'b1;
    point_x_in     = x;
    point_y_in     = y;
    tick();
    point_valid_in = 1'b0;
  endtask

  // Returns the cycle number (accept cycle = 0) in which result_valid_out first appears.
  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!result_valid_out && n < 40) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic take();
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
  endtask

  int  lat;
  logic seen_valid;

  initial begin
    rst_in = 1'b1;
    centroid_we_in = 1'b0; centroid_idx_in = '0; centroid_x_in = '0; centroid_y_in = '0;
    point_valid_in = 1'b0; point_x_in = '0; point_y_in = '0; result_ready_in = 1'b0;
`ifdef NEAREST_CENTROID_ACCUM_EN
    accum_clear_in = 1'b0; accum_rd_idx_in = '0;
`endif
    tick(); tick();
    chk("rst_ready", 32'(point_ready_out), 0);
    chk("rst_valid", 32'(result_valid_out), 0);
    chk("rst_idx", 32'(best_idx_out), 0);
    chk("rst_dist", 32'(best_dist_out), 0);
    rst_in = 1'b0;
    tick();
    chk("post_rst_ready", 32'(point_ready_out), 1);

    // Basic search
    wr(0, 0, 0); wr(1, 100, 50); wr(2, 300, 200); wr(3, 511, 255);
    start(110, 40);
    chk("scan_ready", 32'(point_ready_out), 0);
    wait_done(lat);
    chk("basic_latency", 32'(lat), 5);
    chk("basic_idx", 32'(best_idx_out), 1);
    chk("basic_dist", 32'(best_dist_out), 20);
    take();
    chk("basic_back_idle", 32'(point_ready_out), 1);
    chk("basic_valid_drop", 32'(result_valid_out), 0);

    // Tie goes to lower index
    wr(0, 10, 10); wr(1, 20, 20); wr(2, 0, 0); wr(3, 0, 0);
    start(15, 15);
    wait_done(lat);
    chk("tie_latency", 32'(lat), 5);
    chk("tie_idx", 32'(best_idx_out), 0);
    chk("tie_dist", 32'(best_dist_out), 10);
    take();

    // Maximum distance with back-pressure
    wr(0, 0, 0); wr(1, 0, 0);
    start(511, 255);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(result_valid_out), 1);
      chk("bp_ready", 32'(point_ready_out), 0);
      chk("bp_idx", 32'(best_idx_out), 0);
      chk("bp_dist", 32'(best_dist_out), 766);
      tick();
    end
    take();

    // Write during scan is dropped; centroids all (0,0)
    start(100, 100);
    wr(2, 100, 100);
    wait_done(lat);
    chk("drop_idx", 32'(best_idx_out), 0);
    chk("drop_dist", 32'(best_dist_out), 200);
    take();
    start(100, 100);
    wait_done(lat);
    chk("drop_next_idx", 32'(best_idx_out), 0);
    chk("drop_next_dist", 32'(best_dist_out), 200);
    take();

    // Write in the accepting cycle is seen by that scan
    centroid_we_in = 1'b1; centroid_idx_in = 3; centroid_x_in = 100; centroid_y_in = 100;
    start(100, 100);
    centroid_we_in = 1'b0;
    wait_done(lat);
    chk("same_cyc_idx", 32'(best_idx_out), 3);
    chk("same_cyc_dist", 32'(best_dist_out), 0);
    take();

    // Reset in the second scan cycle abandons the point and clears centroids
    wr(0, 100, 100); wr(1, 100, 100); wr(2, 100, 100);
    start(7, 7);
    tick();
    rst_in = 1'b1;
    #1;
    chk("midrst_ready", 32'(point_ready_out), 0);
    chk("midrst_valid", 32'(result_valid_out), 0);
    tick();
    rst_in = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (result_valid_out) seen_valid = 1'b1;
    end
    chk("midrst_no_result", 32'(seen_valid), 0);
    chk("midrst_ready_after", 32'(point_ready_out), 1);
    start(5, 5);
    wait_done(lat);
    chk("midrst_cleared_idx", 32'(best_idx_out), 0);
    chk("midrst_cleared_dist", 32'(best_dist_out), 10);
    take();

`ifdef NEAREST_CENTROID_ACCUM_EN
    accum_clear_in = 1'b1; tick(); accum_clear_in = 1'b0;
    wr(0, 0, 0); wr(1, 100, 50); wr(2, 300, 200); wr(3, 511, 255);
    start(110, 40); wait_done(lat); take();
    start(90, 60);  wait_done(lat); take();
    start(5, 5);    wait_done(lat); take();
    accum_rd_idx_in = 1; #1;
    chk("acc1_x", 32'(accum_sum_x_out), 200);
    chk("acc1_y", 32'(accum_sum_y_out), 100);
    chk("acc1_n", 32'(accum_count_out), 2);
    accum_rd_idx_in = 0; #1;
    chk("acc0_x", 32'(accum_sum_x_out), 5);
    chk("acc0_y", 32'(accum_sum_y_out), 5);
    chk("acc0_n", 32'(accum_count_out), 1);
    accum_clear_in = 1'b1; tick(); accum_clear_in = 1'b0;
    accum_rd_idx_in = 1; #1;
    chk("acc_clr_x", 32'(accum_sum_x_out), 0);
    chk("acc_clr_n", 32'(accum_count_out), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
